manual_drive_ctrl_v2: RTL and testbench
=======================================

Name: manual_drive_ctrl_v2

Overview:
- Registered manual-transmission car controller, second generation.
- Owns the power, drive and moving-state registers and drives the turn lights, so there is no combinational next-state loop back through the top level.
- Generalised with parametrised timing, a ms tick enable instead of derived clocks, blinking and hazard lights, gear-change fault detection and a mileage counter.
- Sits between the debounced switch/button inputs and the car-motion and display logic.

Parameters:
- POWER_ON_MS, 1000: consecutive ms ticks power_on must be held to power up.
- BLINK_MS, 500: full turn-light blink period in ticks; must be even and >= 2.
- MILE_TICKS, 1000: ticks of motion per mileage increment.
- MILE_W, 16: mileage counter width.
- IDLE_MS, 10000: idle timeout in ticks; used only with AUTO_OFF_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- tick_ms  in  1  one-cycle pulse every 1 ms; all timers advance only on tick cycles.
- power_on, power_off  in  1  power buttons.
- clutch, brake, throttle, rgs, left, right  in  1  driver controls; rgs=1 selects reverse.
- power  out  1  0=off, 1=on.
- state  out  2  00 NSTART, 01 START, 10 MOVING.
- moving_state  out  4  0000 NON_MOVING, 0001 FORWARD, 0010 BACK, 0100 TURN_LEFT, 1000 TURN_RIGHT.
- turn_left_light, turn_right_light  out  1  turn lights.
- mileage  out  MILE_W  motion count.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, state=NSTART, all counters 0, rgs_q=0.
- All outputs are registered. Latency is 1 clk from the deciding input, or from the deciding tick for timed events.
- Power-up:
  - While power=0 and power_on=1, hold_cnt increments on each tick.
  - When hold_cnt reaches POWER_ON_MS-1 and a tick arrives, power goes to 1 and mileage clears.
  - power_on=0 clears hold_cnt immediately.
- Power-down has top priority over every drive rule. It happens on:
  - power_off=1 while powered;
  - NSTART with throttle & ~clutch;
  - MOVING with rgs != rgs_q & ~clutch (gear change without clutch).
  - Effect next cycle: power=0, state=NSTART, moving_state=0, lights 0. Mileage holds.
- rgs_q samples rgs every cycle.
- NSTART:
  - Both lights steady 1; moving_state=0.
  - throttle & clutch & ~brake & ~rgs -> START.
- START:
  - brake -> NSTART.
  - ~clutch & ~brake & throttle -> MOVING.
  - Otherwise stay in START.
- MOVING, priority order:
  1. brake -> NSTART.
  2. clutch & ~throttle -> START; moving_state=0.
  3. Otherwise stay in MOVING.
- moving_state while in (or entering) MOVING:
  - left & ~right -> TURN_LEFT.
  - right & ~left -> TURN_RIGHT.
  - else rgs ? BACK : FORWARD.
- Lights in START/MOVING:
  - left only: left blinks.
  - right only: right blinks.
  - both: hazard, both blink in phase.
  - none: both 0.
  - Blink is on for BLINK_MS/2 ticks, then off for BLINK_MS/2 ticks.
  - The phase counter clears whenever no signal is requested, so the first lit phase is full length.
  - A change of selected side does not reset the phase.
- Mileage:
  - While state=MOVING, mile_cnt counts ticks.
  - When mile_cnt reaches MILE_TICKS-1 on a tick, mileage increments and mile_cnt wraps to 0.
  - Mileage saturates at all-ones. mile_cnt holds outside MOVING.
- Simultaneous events:
  - power_off beats a power_on hold.
  - A tick coinciding with a power-down cycle has no timer effect.
  - A reset mid-hold discards the hold.

Optional Feature:
- Macro: MANUAL_AUTO_OFF_EN.
- Defined:
  - In NSTART with power=1 and throttle, clutch, brake, left and right all 0, idle_cnt counts ticks.
  - Any of those inputs going to 1 clears idle_cnt.
  - When idle_cnt reaches IDLE_MS-1 on a tick, the block powers down as for power_off.
- Undefined: no idle counter exists and IDLE_MS is unused.

Decomposition:
- Package manual_pkg holds:
  - POFF/PON;
  - NSTART/START/MOVING;
  - the five moving_state codes.
- One sub-module: tick_timer.
  - Parametrised WIDTH, LIMIT; inputs clr, en, tick; outputs cnt, hit.
  - Instantiated for the hold, blink, mileage and idle counters.

Test Plan:
- POWER_ON_MS=4: hold power_on for 4 ticks -> power=1 one clk after the 4th tick. Release after 3 ticks then re-hold 3 ticks -> power stays 0.
- Powered in NSTART: throttle=1, clutch=0 -> power=0, lights 0 next clk. Repeat with clutch=1 -> state=START.
- START: clutch=0, throttle=1, left=1 -> state=MOVING, moving_state=0100. Then rgs toggles with clutch=0 -> power=0.
- MOVING forward with clutch=1, rgs=1 -> moving_state=0010. Then brake -> state=NSTART, moving_state=0000.
- BLINK_MS=4, hazard in START -> both lights 1,1,0,0,1 on successive ticks. Release both -> both lights 0 and phase restarts.
- MILE_TICKS=2, MILE_W=2: 10 ticks in MOVING -> mileage 1,2,3,3,3. With MANUAL_AUTO_OFF_EN and IDLE_MS=3, idle in NSTART for 3 ticks -> power=0.

Source files
------------

// File: rtl/manual_pkg.sv
// Shared encodings and the steering helper for the manual drive controller.
package manual_pkg;

  typedef enum logic {
    POFF = 1'b0,
    PON  = 1'b1
  } power_t;

  typedef enum logic [1:0] {
    NSTART = 2'b00,
    START  = 2'b01,
    MOVING = 2'b10
  } drive_t;

  typedef enum logic [3:0] {
    NON_MOVING = 4'b0000,
    FORWARD    = 4'b0001,
    BACK       = 4'b0010,
    TURN_LEFT  = 4'b0100,
    TURN_RIGHT = 4'b1000
  } move_t;

  // A single-sided turn request wins over the gear direction.
  function automatic move_t move_dir(input logic l, input logic r, input logic rev);
    move_t m;
    if (l & ~r)      m = TURN_LEFT;
    else if (r & ~l) m = TURN_RIGHT;
    else if (rev)    m = BACK;
    else             m = FORWARD;
    return m;
  endfunction

endpackage

// File: rtl/manual_drive_ctrl_v2_tick_timer.sv
// Tick-driven modulo-LIMIT counter; hit flags the tick that wraps it. No backpressure.
module tick_timer #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             tick,
  output logic [WIDTH-1:0] cnt,
  output logic             hit
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  assign hit = ~clr & en & tick & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en & tick) begin
      cnt <= hit ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/manual_drive_ctrl_v2.sv
// Registered manual-car controller: power, drive FSM, blinkers, mileage; 1 clk latency, no backpressure.
// Optional idle auto power-off is built when MANUAL_AUTO_OFF_EN is defined.
module manual_drive_ctrl_v2
  import manual_pkg::*;
#(
  parameter int POWER_ON_MS = 1000,
  parameter int BLINK_MS    = 500,
  parameter int MILE_TICKS  = 1000,
  parameter int MILE_W      = 16,
  parameter int IDLE_MS     = 10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_ms,
  input  logic              power_on,
  input  logic              power_off,
  input  logic              clutch,
  input  logic              brake,
  input  logic              throttle,
  input  logic              rgs,
  input  logic              left,
  input  logic              right,
  output logic              power,
  output logic [1:0]        state,
  output logic [3:0]        moving_state,
  output logic              turn_left_light,
  output logic              turn_right_light,
  output logic [MILE_W-1:0] mileage
);

  localparam int HOLD_W  = $clog2(POWER_ON_MS + 1);
  localparam int BLINK_W = $clog2(BLINK_MS + 1);
  localparam int MCNT_W  = $clog2(MILE_TICKS + 1);
  localparam logic [BLINK_W-1:0] HALF = BLINK_W'(BLINK_MS / 2);

  power_t            power_q, power_d;
  drive_t            state_q, state_d;
  move_t             move_q, move_d;
  logic              left_q, left_d, right_q, right_d;
  logic              rgs_q;
  logic [MILE_W-1:0] mileage_q;

  logic              pdown_base, pdown;
  logic              hold_hit, mile_hit, blink_hit, blink_run, blink_on;
  logic [HOLD_W-1:0] hold_cnt_unused;
  logic [MCNT_W-1:0] mile_cnt_unused;
  logic [BLINK_W-1:0] blink_cnt, blink_nxt;

  assign power            = power_q;
  assign state            = state_q;
  assign moving_state     = move_q;
  assign turn_left_light  = left_q;
  assign turn_right_light = right_q;
  assign mileage          = mileage_q;

  assign pdown_base = (power_q == PON) &
                      (power_off |
                       ((state_q == NSTART) & throttle & ~clutch) |
                       ((state_q == MOVING) & (rgs != rgs_q) & ~clutch));

`ifdef MANUAL_AUTO_OFF_EN
  localparam int IDLE_W = $clog2(IDLE_MS + 1);
  logic              idle_ok, idle_hit;
  logic [IDLE_W-1:0] idle_cnt_unused;

  assign idle_ok = (power_q == PON) & (state_q == NSTART) &
                   ~(throttle | clutch | brake | left | right);

  tick_timer #(.WIDTH(IDLE_W), .LIMIT(IDLE_MS)) u_idle (
    .clk(clk), .rst(rst), .clr(~idle_ok), .en(idle_ok & ~pdown_base),
    .tick(tick_ms), .cnt(idle_cnt_unused), .hit(idle_hit)
  );

  assign pdown = pdown_base | idle_hit;
`else
  logic idle_unused;
  assign idle_unused = (IDLE_MS > 0);
  assign pdown       = pdown_base;
`endif

  // power_off in the clear term makes it win over a completing hold.
  tick_timer #(.WIDTH(HOLD_W), .LIMIT(POWER_ON_MS)) u_hold (
    .clk(clk), .rst(rst), .clr((power_q == PON) | ~power_on | power_off),
    .en((power_q == POFF) & power_on), .tick(tick_ms),
    .cnt(hold_cnt_unused), .hit(hold_hit)
  );

  tick_timer #(.WIDTH(MCNT_W), .LIMIT(MILE_TICKS)) u_mile (
    .clk(clk), .rst(rst), .clr(1'b0), .en((state_q == MOVING) & ~pdown),
    .tick(tick_ms), .cnt(mile_cnt_unused), .hit(mile_hit)
  );

  assign blink_run = (power_q == PON) & (state_q != NSTART) & (left | right);

  tick_timer #(.WIDTH(BLINK_W), .LIMIT(BLINK_MS)) u_blink (
    .clk(clk), .rst(rst), .clr(~blink_run), .en(blink_run & ~pdown),
    .tick(tick_ms), .cnt(blink_cnt), .hit(blink_hit)
  );

  // Lights are registered, so decide them from the phase the counter moves to.
  always_comb begin
    blink_nxt = blink_cnt;
    if (!blink_run)              blink_nxt = '0;
    else if (blink_hit)          blink_nxt = '0;
    else if (tick_ms & ~pdown)   blink_nxt = blink_cnt + 1'b1;
  end

  assign blink_on = (blink_nxt < HALF);

  always_comb begin
    power_d = power_q;
    state_d = state_q;
    move_d  = move_q;
    left_d  = 1'b0;
    right_d = 1'b0;

    if (power_q == POFF) begin
      state_d = NSTART;
      move_d  = NON_MOVING;
      if (hold_hit) power_d = PON;
    end else if (pdown) begin
      power_d = POFF;
      state_d = NSTART;
      move_d  = NON_MOVING;
    end else begin
      case (state_q)
        NSTART: begin
          if (throttle & clutch & ~brake & ~rgs) state_d = START;
        end
        START: begin
          if (brake) begin
            state_d = NSTART;
          end else if (~clutch & throttle) begin
            state_d = MOVING;
            move_d  = move_dir(left, right, rgs);
          end
        end
        MOVING: begin
          if (brake) begin
            state_d = NSTART;
            move_d  = NON_MOVING;
          end else if (clutch & ~throttle) begin
            state_d = START;
            move_d  = NON_MOVING;
          end else begin
            move_d  = move_dir(left, right, rgs);
          end
        end
        default: begin
          state_d = NSTART;
          move_d  = NON_MOVING;
        end
      endcase
    end

    if (power_d == PON) begin
      if (state_d == NSTART) begin
        left_d  = 1'b1;
        right_d = 1'b1;
      end else begin
        left_d  = left & blink_on;
        right_d = right & blink_on;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      power_q   <= POFF;
      state_q   <= NSTART;
      move_q    <= NON_MOVING;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      rgs_q     <= 1'b0;
      mileage_q <= '0;
    end else begin
      power_q <= power_d;
      state_q <= state_d;
      move_q  <= move_d;
      left_q  <= left_d;
      right_q <= right_d;
      rgs_q   <= rgs;
      if (hold_hit)
        mileage_q <= '0;
      else if (mile_hit && (mileage_q != '1))
        mileage_q <= mileage_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_manual_drive_ctrl_v2.sv
// Directed bench for manual_drive_ctrl_v2 with a per-cycle behavioural model.
module tb_manual_drive_ctrl_v2;

  localparam int PON_MS = 4;
  localparam int BLINK  = 4;
  localparam int MT     = 2;
  localparam int MW     = 2;
  localparam int IDLE   = 3;

  logic clk = 1'b0;
  logic rst, tick_ms, power_on, power_off, clutch, brake, throttle, rgs, left, right;
  logic power, turn_left_light, turn_right_light;
  logic [1:0] state;
  logic [3:0] moving_state;
  logic [MW-1:0] mileage;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  manual_drive_ctrl_v2 #(
    .POWER_ON_MS(PON_MS), .BLINK_MS(BLINK), .MILE_TICKS(MT), .MILE_W(MW), .IDLE_MS(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .power_on(power_on), .power_off(power_off),
    .clutch(clutch), .brake(brake), .throttle(throttle), .rgs(rgs), .left(left), .right(right),
    .power(power), .state(state), .moving_state(moving_state),
    .turn_left_light(turn_left_light), .turn_right_light(turn_right_light), .mileage(mileage)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integers, updated from the inputs seen at each rising edge.
  int m_power, m_st, m_ms, m_ll, m_rl, m_mileage, m_hold, m_phase, m_mcnt, m_idle, m_rq;
  int mpd, mpdb, msig, midle_ok, mdir, mon;

  always @(posedge clk) begin
    if (!rst) begin
      m_power = 0; m_st = 0; m_ms = 0; m_ll = 0; m_rl = 0; m_mileage = 0;
      m_hold = 0; m_phase = 0; m_mcnt = 0; m_idle = 0; m_rq = 0;
    end else begin
      mpdb = int'(m_power != 0 && (power_off || (m_st == 0 && throttle && !clutch) ||
                                   (m_st == 2 && rgs != m_rq[0] && !clutch)));
      midle_ok = int'(m_power != 0 && m_st == 0 && !(throttle || clutch || brake || left || right));
      mpd = mpdb;
`ifdef MANUAL_AUTO_OFF_EN
      if (midle_ok == 0) m_idle = 0;
      else if (tick_ms && mpdb == 0) begin
        if (m_idle == IDLE - 1) begin mpd = 1; m_idle = 0; end
        else m_idle = m_idle + 1;
      end
`endif
      if (m_power == 0) begin
        if (!power_on || power_off) m_hold = 0;
        else if (tick_ms) begin
          if (m_hold == PON_MS - 1) begin
            m_hold = 0; m_power = 1; m_mileage = 0; m_ll = 1; m_rl = 1;
          end else m_hold = m_hold + 1;
        end
      end else if (mpd != 0) begin
        m_power = 0; m_st = 0; m_ms = 0; m_ll = 0; m_rl = 0;
      end else begin
        if (m_st == 2 && tick_ms) begin
          if (m_mcnt == MT - 1) begin
            m_mcnt = 0;
            if (m_mileage < (1 << MW) - 1) m_mileage = m_mileage + 1;
          end else m_mcnt = m_mcnt + 1;
        end
        msig = int'(m_st != 0 && (left || right));
        if (msig == 0) m_phase = 0;
        else if (tick_ms) m_phase = (m_phase + 1) % BLINK;
        mdir = (left && !right) ? 4 : (right && !left) ? 8 : (rgs ? 2 : 1);
        case (m_st)
          0: if (throttle && clutch && !brake && !rgs) m_st = 1;
          1: if (brake) m_st = 0;
             else if (!clutch && throttle) begin m_st = 2; m_ms = mdir; end
          2: if (brake) begin m_st = 0; m_ms = 0; end
             else if (clutch && !throttle) begin m_st = 1; m_ms = 0; end
             else m_ms = mdir;
          default: m_st = 0;
        endcase
        if (m_st == 0) begin
          m_ll = 1; m_rl = 1;
        end else begin
          mon = int'(m_phase < BLINK / 2);
          m_ll = int'(left && mon != 0);
          m_rl = int'(right && mon != 0);
        end
      end
      m_rq = int'(rgs);
    end
  end

  always @(negedge clk) begin
    logic [10:0] got, exp;
    if (cmp_on) begin
      got = {power, state, moving_state, turn_left_light, turn_right_light, mileage};
      exp = {m_power[0], m_st[1:0], m_ms[3:0], m_ll[0], m_rl[0], m_mileage[MW-1:0]};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL model_cycle t=%0t: got %b required %b", $time, got, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse();
    tick_ms = 1'b1; step();
    tick_ms = 1'b0; step();
  endtask

  task automatic all_zero();
    {power_on, power_off, clutch, brake, throttle, rgs, left, right} = '0;
  endtask

  task automatic power_up();
    power_on = 1'b1;
    repeat (PON_MS) pulse();
    power_on = 1'b0;
    step();
  endtask

  logic [1:0] hazard_exp [5];
  logic [MW-1:0] mile_exp [5];

  initial begin
    hazard_exp = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b11};
    mile_exp   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b0; tick_ms = 1'b0; all_zero();
    step();
    cmp_on = 1'b1;
    step();
    chk("reset_power", power, 0);
    chk("reset_state", state, 0);
    chk("reset_lights", {turn_left_light, turn_right_light}, 0);
    chk("reset_mileage", mileage, 0);
    rst = 1'b1;

    // Power-up hold, including an interrupted hold.
    power_on = 1'b1;
    repeat (3) pulse();
    chk("hold3_no_power", power, 0);
    power_on = 1'b0; step(); power_on = 1'b1;
    repeat (3) pulse();
    chk("rehold3_no_power", power, 0);
    pulse();
    chk("hold4_power_up", power, 1);
    chk("nstart_lights", {turn_left_light, turn_right_light}, 3);
    power_on = 1'b0;

    // Throttle without clutch in NSTART stalls the car.
    throttle = 1'b1; step();
    chk("stall_power", power, 0);
    chk("stall_lights", {turn_left_light, turn_right_light}, 0);
    throttle = 1'b0;
    power_up();
    throttle = 1'b1; clutch = 1'b1; step();
    chk("nstart_to_start", state, 1);

    // START to MOVING turning left, then gear change without clutch.
    clutch = 1'b0; left = 1'b1; step();
    chk("start_to_moving", state, 2);
    chk("moving_left", moving_state, 4'b0100);
    rgs = 1'b1; step();
    chk("gear_no_clutch_off", power, 0);
    all_zero();

    // Forward, reverse with clutch, then brake.
    power_up();
    throttle = 1'b1; clutch = 1'b1; step();
    clutch = 1'b0; step();
    chk("moving_forward", moving_state, 4'b0001);
    clutch = 1'b1; rgs = 1'b1; step();
    chk("moving_back", moving_state, 4'b0010);
    chk("moving_back_state", state, 2);
    brake = 1'b1; step();
    chk("brake_state", state, 0);
    chk("brake_moving_state", moving_state, 0);
    all_zero(); step();

    // Hazard blink in START, then release and restart the phase.
    throttle = 1'b1; clutch = 1'b1; step();
    throttle = 1'b0; left = 1'b1; right = 1'b1; step();
    chk("hazard_0", {turn_left_light, turn_right_light}, hazard_exp[0]);
    for (int i = 1; i < 5; i++) begin
      pulse();
      chk($sformatf("hazard_%0d", i), {turn_left_light, turn_right_light}, hazard_exp[i]);
    end
    left = 1'b0; right = 1'b0; step();
    chk("hazard_release", {turn_left_light, turn_right_light}, 0);
    left = 1'b1; step();
    chk("left_restart", {turn_left_light, turn_right_light}, 2'b10);
    pulse();
    chk("left_tick1", turn_left_light, 1);
    pulse();
    chk("left_tick2", turn_left_light, 0);
    left = 1'b0;

    // Mileage with saturation.
    clutch = 1'b0; throttle = 1'b1; step();
    chk("mile_moving", state, 2);
    for (int i = 1; i <= 10; i++) begin
      pulse();
      if (i % 2 == 0) chk($sformatf("mileage_%0d", i), mileage, mile_exp[i / 2 - 1]);
    end
    power_off = 1'b1; step();
    chk("power_off", power, 0);
    chk("mileage_holds", mileage, 3);
    all_zero();

    // power_off beats a hold; reset discards a hold.
    power_on = 1'b1; power_off = 1'b1;
    repeat (5) pulse();
    chk("off_beats_hold", power, 0);
    power_off = 1'b0;
    repeat (3) pulse();
    rst = 1'b0; step(); rst = 1'b1;
    pulse();
    chk("reset_discards_hold", power, 0);
    repeat (3) pulse();
    chk("hold_after_reset", power, 1);
    power_on = 1'b0;

    // A tick during a power-down cycle must not advance mileage.
    throttle = 1'b1; clutch = 1'b1; step();
    clutch = 1'b0; step();
    pulse();
    tick_ms = 1'b1; power_off = 1'b1; step();
    tick_ms = 1'b0; all_zero(); step();
    chk("pdown_tick_power", power, 0);
    chk("pdown_tick_mileage", mileage, 0);

    // Idle in NSTART.
    power_up();
    repeat (IDLE - 1) pulse();
    chk("idle_before_limit", power, 1);
    pulse();
`ifdef MANUAL_AUTO_OFF_EN
    chk("idle_auto_off", power, 0);
`else
    chk("idle_no_auto_off", power, 1);
`endif

    step();
    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
